// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM encoding,
// access-size decode and byte-enable generation.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_e;

  // Unused funct3 codes fall through to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SIZE_B;
      F3_H, F3_HU: return SIZE_H;
      default:     return SIZE_W;
    endcase
  endfunction

  function automatic logic [3:0] size_be(input lsu_size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 4'b0001 << lane;
      SIZE_H:  return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage: runs one load/store per request over the req/gnt/rvalid bus, places store
// lanes, extends load data and raises misalign / bus-timeout faults.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = 255,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_is_store,
  input  logic [2:0]               ex_funct3,
  input  logic [31:0]              ex_addr,
  input  logic [31:0]              ex_wdata,
  input  logic [4:0]               ex_rd,
  output logic                     lsu_busy,
  load_store_unit_if.master        mem,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     misalign,
  output logic                     bus_err,
  output logic [31:0]              bad_addr
);

  localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  lsu_state_e  state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [1:0]  lane_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        req_q;
  logic [CntW-1:0] cnt_q;

  lsu_size_e   ex_size;
  logic [1:0]  ex_lane;
  logic [31:0] ex_lane_wdata;
  logic        ex_mis;
  logic        timeout_hit;
  logic [31:0] load_data;

  // Lane used on the bus is the naturally aligned one, which also implements forced alignment.
  always_comb begin
    ex_size       = f3_size(ex_funct3);
    ex_lane       = ex_addr[1:0];
    ex_lane_wdata = ex_wdata;
    ex_mis        = 1'b0;
    unique case (ex_size)
      SIZE_B: ex_lane_wdata = {4{ex_wdata[7:0]}};
      SIZE_H: begin
        ex_lane       = {ex_addr[1], 1'b0};
        ex_mis        = ex_addr[0];
        ex_lane_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        ex_lane = 2'b00;
        ex_mis  = |ex_addr[1:0];
      end
    endcase
  end

  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == CntW'(BUS_TIMEOUT - 1));

  lsu_load_align u_load_align (
    .rdata  (mem.mem_rdata),
    .addr   (lane_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      lane_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      bad_addr   <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid) begin
            is_store_q <= ex_is_store;
            funct3_q   <= ex_funct3;
            addr_q     <= ex_addr;
            lane_q     <= ex_lane;
            be_q       <= size_be(ex_size, ex_lane);
            wdata_q    <= ex_lane_wdata;
            rd_q       <= ex_rd;
            if (MISALIGN_TRAP && ex_mis) begin
              state_q  <= DONE;
              misalign <= 1'b1;
              bad_addr <= ex_addr;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        REQ: begin
          // A same-cycle rvalid is stale: only the grant is taken here.
          if (mem.mem_gnt) begin
            state_q <= RESP;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            state_q  <= DONE;
            req_q    <= 1'b0;
            bus_err  <= 1'b1;
            bad_addr <= addr_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (mem.mem_rvalid) begin
            state_q <= DONE;
            if (!is_store_q) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= load_data;
            end
          end else if (timeout_hit) begin
            state_q  <= DONE;
            bus_err  <= 1'b1;
            bad_addr <= addr_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_busy      = (state_q != IDLE);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = is_store_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a cycle-level behavioural model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  load_store_unit_if bus0 ();
  load_store_unit_if bus1 ();
  assign bus0.mem_gnt = gnt;
  assign bus0.mem_rvalid = rvalid;
  assign bus0.mem_rdata = rdata;
  assign bus1.mem_gnt = gnt;
  assign bus1.mem_rvalid = rvalid;
  assign bus1.mem_rdata = rdata;

  logic busy0, wbv0, mis0, err0, busy1, wbv1, mis1, err1;
  logic [4:0] wbrd0, wbrd1;
  logic [31:0] wbd0, bad0, wbd1, bad1;

  load_store_unit #(.BUS_TIMEOUT(255), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(busy0), .mem(bus0), .wb_valid(wbv0), .wb_rd(wbrd0), .wb_data(wbd0),
    .misalign(mis0), .bus_err(err0), .bad_addr(bad0)
  );

  load_store_unit #(.BUS_TIMEOUT(4), .MISALIGN_TRAP(1'b1)) dut_to (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(busy1), .mem(bus1), .wb_valid(wbv1), .wb_rd(wbrd1), .wb_data(wbd1),
    .misalign(mis1), .bus_err(err1), .bad_addr(bad1)
  );

  // Observed outputs of whichever instance is under check.
  bit sel = 1'b0;
  logic a_busy, a_req, a_we, a_wbv, a_mis, a_err;
  logic [3:0] a_be;
  logic [4:0] a_rd;
  logic [31:0] a_addr, a_wdata, a_wbd, a_bad;
  always_comb begin
    a_busy = sel ? busy1 : busy0;
    a_req = sel ? bus1.mem_req : bus0.mem_req;
    a_we = sel ? bus1.mem_we : bus0.mem_we;
    a_addr = sel ? bus1.mem_addr : bus0.mem_addr;
    a_be = sel ? bus1.mem_be : bus0.mem_be;
    a_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
    a_wbv = sel ? wbv1 : wbv0;
    a_rd = sel ? wbrd1 : wbrd0;
    a_wbd = sel ? wbd1 : wbd0;
    a_mis = sel ? mis1 : mis0;
    a_err = sel ? err1 : err0;
    a_bad = sel ? bad1 : bad0;
  end

  int checks = 0, errors = 0;
  bit chk_en = 1'b0, e_zero = 1'b0;
  logic e_busy, e_req, e_we, e_wbv, e_mis, e_err;
  logic [3:0] e_be;
  logic [4:0] e_rd;
  logic [31:0] e_addr, e_wdata, e_wbd, e_bad;
  logic [31:0] cur_bad = '0;

  int req_cycles = 0, wb_pulses = 0, err_pulses = 0;
  logic [31:0] last_wb, last_addr, last_wdata;
  logic [3:0] last_be;
  logic last_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lsu_busy", 32'(a_busy), 32'(e_busy));
      chk("mem_req", 32'(a_req), 32'(e_req));
      if (e_req) begin
        chk("mem_we", 32'(a_we), 32'(e_we));
        chk("mem_addr", a_addr, e_addr);
        chk("mem_be", 32'(a_be), 32'(e_be));
        chk("mem_wdata", a_wdata, e_wdata);
      end
      if (e_zero) begin
        chk("mem_we_rst", 32'(a_we), 32'd0);
        chk("mem_addr_rst", a_addr, 32'd0);
        chk("mem_be_rst", 32'(a_be), 32'd0);
        chk("mem_wdata_rst", a_wdata, 32'd0);
        chk("wb_data_rst", a_wbd, 32'd0);
      end
      chk("wb_valid", 32'(a_wbv), 32'(e_wbv));
      if (e_wbv) begin
        chk("wb_rd", 32'(a_rd), 32'(e_rd));
        chk("wb_data", a_wbd, e_wbd);
      end
      chk("misalign", 32'(a_mis), 32'(e_mis));
      chk("bus_err", 32'(a_err), 32'(e_err));
      chk("bad_addr", a_bad, e_bad);
    end
    if (a_req) begin
      req_cycles++;
      last_addr = a_addr; last_be = a_be; last_wdata = a_wdata; last_we = a_we;
    end
    if (a_wbv) begin wb_pulses++; last_wb = a_wbd; end
    if (a_err) err_pulses++;
  end

  // ---------------- behavioural model ----------------
  function automatic int unsigned m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int unsigned m_lane(input logic [2:0] f3, input logic [31:0] a);
    int unsigned lo = a % 4;
    return lo - (lo % m_size(f3));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned m = ((1 << m_size(f3)) - 1) << m_lane(f3, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int unsigned n = m_size(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rw, input logic [31:0] a,
                                         input logic [2:0] f3);
    int unsigned n = m_size(f3);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    logic [31:0] v = (rw >> (8 * m_lane(f3, a))) & mask;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    e_busy = 0; e_req = 0; e_wbv = 0; e_mis = 0; e_err = 0; e_bad = cur_bad; e_zero = 0;
  endtask

  // Upstream keeps ex_valid high with garbage while busy; the DUT must ignore it.
  task automatic junk_ex();
    ex_valid = 1'b1; ex_is_store = 1'($urandom); ex_funct3 = 3'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
  endtask

  task automatic idle();
    cyc();
    ex_valid = 1'b0; gnt = 1'b0; rvalid = 1'($urandom); rdata = $urandom;
    exp_idle();
  endtask

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int gd,
                        input int rdl, input logic [31:0] rword, input int to);
    bit to_hit = 1'b0;
    cyc();
    ex_valid = 1'b1; ex_is_store = st; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    gnt = 1'b0; rvalid = 1'($urandom); rdata = $urandom;
    exp_idle();
    if ((a % m_size(f3)) != 0) begin
      cyc(); junk_ex(); rvalid = 1'($urandom);
      cur_bad = a;
      exp_idle(); e_busy = 1; e_mis = 1;
      return;
    end
    for (int i = 0; ; i++) begin
      cyc(); junk_ex();
      gnt = (i == gd); rvalid = 1'($urandom); rdata = $urandom;
      exp_idle(); e_busy = 1; e_req = 1; e_we = st;
      e_addr = a & ~32'd3; e_be = m_be(f3, a); e_wdata = m_wdata(f3, wd);
      if (i == gd) break;
      if (to != 0 && i == to - 1) begin to_hit = 1; break; end
    end
    if (!to_hit) begin
      for (int j = 0; ; j++) begin
        cyc(); junk_ex();
        gnt = 1'b0; rvalid = (j == rdl); rdata = (j == rdl) ? rword : $urandom;
        exp_idle(); e_busy = 1;
        if (j == rdl) break;
        if (to != 0 && j == to - 1) begin to_hit = 1; break; end
      end
    end
    cyc(); junk_ex(); gnt = 1'b0; rvalid = 1'($urandom); rdata = $urandom;
    if (to_hit) cur_bad = a;
    exp_idle(); e_busy = 1; e_err = to_hit;
    e_wbv = !st && !to_hit; e_rd = rd; e_wbd = m_load(rword, a, f3);
  endtask

  initial begin
    int base;
    rst = 1'b1; ex_valid = 0; ex_is_store = 0; ex_funct3 = 0; ex_addr = 0; ex_wdata = 0;
    ex_rd = 0; gnt = 0; rvalid = 0; rdata = 0;
    cyc();
    exp_idle(); e_zero = 1; chk_en = 1;
    cyc(); rst = 1'b0;
    idle();

    // LW, immediate gnt/rvalid.
    run_op(0, F3_W, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 255);
    idle();
    chk("lw_data", last_wb, 32'hDEAD_BEEF);
    chk("lw_be", 32'(last_be), 32'hF);

    run_op(0, F3_B, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80FF_0000, 255);
    idle();
    chk("lb_data", last_wb, 32'hFFFF_FF80);
    run_op(0, F3_BU, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80FF_0000, 255);
    idle();
    chk("lbu_data", last_wb, 32'h0000_0080);
    run_op(0, F3_HU, 32'h102, 32'h0, 5'd0, 0, 1, 32'h80FF_0000, 255);
    idle();
    chk("lhu_data", last_wb, 32'h0000_80FF);

    base = wb_pulses;
    run_op(1, F3_H, 32'h202, 32'h1234_ABCD, 5'd9, 0, 0, 32'h0, 255);
    idle();
    chk("sh_addr", last_addr, 32'h200);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(last_we), 32'd1);
    chk("sh_no_wb", wb_pulses - base, 0);

    base = req_cycles;
    run_op(0, F3_W, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0, 255);
    idle();
    chk("mis_no_req", req_cycles - base, 0);
    chk("mis_bad_addr", a_bad, 32'h101);

    // Grant withheld for five cycles.
    base = req_cycles;
    run_op(0, F3_H, 32'h44, 32'h0, 5'd1, 5, 0, 32'h8001_7FFE, 255);
    idle();
    chk("slow_gnt_req_cycles", req_cycles - base, 6);

    for (int k = 0; k < 150; k++) begin
      bit st = 1'($urandom);
      logic [2:0] f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(m_size(f3) - 1);
      run_op(st, f3, a, $urandom, 5'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
             $urandom, 255);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle();
    end

    // Reset while waiting for rvalid; the late response must be ignored.
    idle();
    ex_valid = 1; ex_is_store = 0; ex_funct3 = F3_W; ex_addr = 32'h300; ex_rd = 5'd4;
    cyc(); ex_valid = 0; gnt = 1; rvalid = 0;
    exp_idle(); e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h300; e_be = 4'hF;
    e_wdata = m_wdata(F3_W, ex_wdata);
    cyc(); gnt = 0; exp_idle(); e_busy = 1;
    cyc(); rst = 1; cur_bad = '0; exp_idle(); e_zero = 1;
    cyc(); rst = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      cyc(); rvalid = 1'($urandom); exp_idle(); e_zero = 1;
    end
    idle();

    // Short-timeout instance, grant never arrives.
    sel = 1'b1;
    base = err_pulses;
    run_op(0, F3_W, 32'h400, 32'h0, 5'd2, 1000, 0, 32'h0, 4);
    idle();
    chk("to_bus_err", err_pulses - base, 1);
    chk("to_bad_addr", a_bad, 32'h400);
    idle();

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
